// File: rtl/chaos_snd.sv
// rtl/chaos_snd.sv - chaotic-map sonifier: serial map iterator, r sweep, NCO bank, delta-sigma mixer
// Tent map path compiled in only when CHAOS_SND_TENT_EN is defined.
module chaos_snd #(
  parameter int FRAC       = 8,
  parameter int N_OSC      = 4,
  parameter int ITER_LEN   = 100,
  parameter int R_INC      = 1000,
  parameter int R_MIN      = 'h110,
  parameter int R_MAX      = 'h3FF,
  parameter int R_STEP     = 4,
  parameter int X_INIT     = 1 << (FRAC - 1),
  parameter int PHASE_BITS = 16,
  parameter int LO_INC     = 32,
  parameter int SPAN_INC   = 160,
  parameter int DIV        = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         map_sel,
  input  logic [1:0]                   sweep_mode,
  input  logic [$clog2(N_OSC+1)-1:0]   osc_count,
  output logic                         snd,
  output logic [FRAC-1:0]              x_out,
  output logic [FRAC+1:0]              r_out,
  output logic                         x_valid
);

  localparam int CW = $clog2(ITER_LEN);
  localparam int SW = $clog2(R_INC + 1);
  localparam int KW = $clog2(N_OSC);
  localparam int AW = $clog2(N_OSC + 1);
  localparam int DW = $clog2(DIV);
  localparam int MW = 2 * FRAC + 2;
  localparam int RW = FRAC + 3;
  localparam int FW = PHASE_BITS + FRAC;

  localparam logic [CW-1:0]   END1   = CW'(FRAC);
  localparam logic [CW-1:0]   END2   = CW'(2 * FRAC + 2);
  localparam logic [CW-1:0]   LAST   = CW'(ITER_LEN - 1);
  localparam logic [FRAC+1:0] X_TOP  = (FRAC+2)'((1 << FRAC) - 1);

  typedef enum logic [1:0] {WAIT, MUL1, MUL2, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [MW-1:0]         mul_acc, mul_a, mul_sum;
  logic [FRAC+1:0]       mul_b;
  logic [FRAC+1:0]       q_wide;
  logic [FRAC-1:0]       p_next, q_next, q_reg, x_reg;
  logic [RW-1:0]         r_reg, r_up, r_nxt;
  logic                  dir_down, dir_nxt;
  logic [SW-1:0]         step_cnt;
  logic [PHASE_BITS-1:0] freq  [N_OSC];
  logic [PHASE_BITS-1:0] phase [N_OSC];
  logic [PHASE_BITS-1:0] freq_new;
  logic [KW-1:0]         k;
  logic [AW-1:0]         active, act_req, acc_mix, acc_nxt, high_cnt;
  logic [AW:0]           mix_sum;
  logic [DW-1:0]         div_cnt;
  logic                  sweep_now, snd_nxt;

`ifdef CHAOS_SND_TENT_EN
  logic                  tent;
  logic [FRAC-1:0]       x_inv;
`else
  logic                  unused_map_sel;
  assign unused_map_sel = map_sel;
`endif

  assign x_out     = x_reg;
  assign r_out     = r_reg[FRAC+1:0];
  assign sweep_now = (state == HOLD) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    mul_sum   = mul_acc + (mul_b[0] ? mul_a : '0);
    q_wide    = (FRAC+2)'(mul_sum >> FRAC);
`ifdef CHAOS_SND_TENT_EN
    x_inv     = ~x_reg;
    p_next    = tent ? ((x_reg < x_inv) ? x_reg : x_inv) : FRAC'(mul_sum >> FRAC);
`else
    p_next    = FRAC'(mul_sum >> FRAC);
`endif
    // Saturate the top and keep the orbit off the zero fixed point.
    if (q_wide > X_TOP)       q_next = '1;
    else if (q_wide == '0)    q_next = FRAC'(1);
    else                      q_next = q_wide[FRAC-1:0];
    case (state)
      WAIT:    if (cnt == '0)  state_nxt = MUL1;
      MUL1:    if (cnt == END1) state_nxt = MUL2;
      MUL2:    if (cnt == END2) state_nxt = HOLD;
      HOLD:    if (cnt == LAST) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_comb begin
    r_up    = r_reg + RW'(R_STEP);
    r_nxt   = r_reg;
    dir_nxt = dir_down;
    case (sweep_mode)
      2'b00: r_nxt = (r_up > RW'(R_MAX)) ? RW'(R_MIN) : r_up;
      2'b01: begin
        if (!dir_down) begin
          if (r_up >= RW'(R_MAX)) begin r_nxt = RW'(R_MAX); dir_nxt = 1'b1; end
          else r_nxt = r_up;
        end else begin
          if (r_reg <= RW'(R_MIN + R_STEP)) begin r_nxt = RW'(R_MIN); dir_nxt = 1'b0; end
          else r_nxt = r_reg - RW'(R_STEP);
        end
      end
      default: ;
    endcase
    act_req = osc_count;
    if (osc_count == '0)              act_req = AW'(1);
    else if (osc_count > AW'(N_OSC))  act_req = AW'(N_OSC);
    freq_new = PHASE_BITS'(LO_INC) + PHASE_BITS'((FW'(SPAN_INC) * FW'(q_reg)) >> FRAC);
    high_cnt = '0;
    for (int i = 0; i < N_OSC; i++)
      if ((AW'(i) < active) && phase[i][PHASE_BITS-1]) high_cnt = high_cnt + AW'(1);
    mix_sum = {1'b0, acc_mix} + {1'b0, high_cnt};
    snd_nxt = (mix_sum >= {1'b0, active});
    acc_nxt = snd_nxt ? AW'(mix_sum - {1'b0, active}) : AW'(mix_sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT;
      cnt     <= '0;
      mul_acc <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      q_reg   <= '0;
      x_reg   <= FRAC'(X_INIT);
      x_valid <= 1'b0;
`ifdef CHAOS_SND_TENT_EN
      tent    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
      x_valid <= 1'b0;
      case (state)
        WAIT: if (cnt == '0) begin
          mul_acc <= '0;
          mul_a   <= MW'(x_reg);
`ifdef CHAOS_SND_TENT_EN
          tent    <= map_sel;
          mul_b   <= map_sel ? '0 : {2'b00, ~x_reg};
`else
          mul_b   <= {2'b00, ~x_reg};
`endif
        end
        MUL1, MUL2: begin
          mul_acc <= mul_sum;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          if (state == MUL1 && cnt == END1) begin
            mul_acc <= '0;
            mul_a   <= MW'(p_next);
            mul_b   <= r_reg[FRAC+1:0];
          end
          if (state == MUL2 && cnt == END2) q_reg <= q_next;
        end
        HOLD: if (cnt == LAST) begin
          x_reg   <= q_reg;
          x_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg    <= RW'(R_MIN);
      dir_down <= 1'b0;
      step_cnt <= '0;
      k        <= '0;
      active   <= AW'(N_OSC);
      acc_mix  <= '0;
      snd      <= 1'b0;
      div_cnt  <= '0;
      for (int i = 0; i < N_OSC; i++) begin
        freq[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      snd     <= snd_nxt;
      acc_mix <= acc_nxt;
      div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);
      if (div_cnt == DW'(DIV - 1))
        for (int i = 0; i < N_OSC; i++) phase[i] <= phase[i] + freq[i];
      if (sweep_now) begin
        freq[k] <= freq_new;
        if (AW'(k) == active - AW'(1)) begin
          k      <= '0;
          active <= act_req;
        end else begin
          k <= k + KW'(1);
        end
        if (step_cnt == SW'(R_INC - 1)) begin
          step_cnt <= '0;
          r_reg    <= r_nxt;
          dir_down <= dir_nxt;
        end else begin
          step_cnt <= step_cnt + SW'(1);
        end
      end
    end
  end

endmodule
